axis_pkt_rr_arbiter: RTL and testbench
======================================

Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 24-bit AXI4-Stream master port between NUM_SI stream sources.
- Typical sources are the switch example masters or the reorder datapath producers. The output feeds the axis_switch slave interface.
- A grant is held from the first beat to the TLAST beat, so packets are never interleaved.
- The source index is emitted on TDEST for downstream routing.

Parameters:
NUM_SI, 2, number of slave (source) stream ports; legal 2..8.
TDATA_W, 24, stream data width in bits; must be a multiple of 8.
TUSER_W, 1, stream user width in bits.
GRANT_W, derived = max(1, clog2(NUM_SI)), grant/TDEST width; not user-set.

Ports:
aclk  in  1  sole clock; all logic on the rising edge.
areset  in  1  asynchronous, active-high reset.
arb_en  in  NUM_SI  per-source enable mask; a 0 bit excludes that source from new grants.
s_axis_tvalid  in  NUM_SI  source valid, one bit per source.
s_axis_tready  out  NUM_SI  source ready, one bit per source.
s_axis_tdata  in  NUM_SI*TDATA_W  source data; source k occupies slice [k*TDATA_W +: TDATA_W].
s_axis_tkeep  in  NUM_SI*TDATA_W/8  source byte keep.
s_axis_tlast  in  NUM_SI  source end-of-packet.
s_axis_tuser  in  NUM_SI*TUSER_W  source user sideband.
m_axis_tvalid  out  1  master valid.
m_axis_tready  in  1  master ready.
m_axis_tdata  out  TDATA_W  master data.
m_axis_tkeep  out  TDATA_W/8  master byte keep.
m_axis_tlast  out  1  master end-of-packet.
m_axis_tuser  out  TUSER_W  master user sideband.
m_axis_tdest  out  GRANT_W  index of the granted source.
busy  out  1  high while a packet is in flight.
pkt_done  out  1  one-cycle pulse after each completed packet.

Behaviour:
Reset (async, areset=1):
- State = IDLE; last_grant = NUM_SI-1, so source 0 has first priority.
- grant = 0; busy = 0; pkt_done = 0.
- All s_axis_tready = 0 and m_axis_tvalid = 0 immediately, without waiting for a clock edge.

State IDLE:
- m_axis_tvalid = 0 and all s_axis_tready = 0.
- req = s_axis_tvalid & arb_en.
- If req != 0: pick the first set bit searching (last_grant+1) mod NUM_SI upward with wrap. Register it into grant; busy <= 1; go to XFER.
- If req == 0: stay in IDLE.

State XFER:
- Combinational mux from source[grant] to the master: m_axis_tvalid/tdata/tkeep/tlast/tuser.
- m_axis_tdest = grant.
- s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0.
- A beat transfers when m_axis_tvalid & m_axis_tready.
- On a beat with tlast=1: last_grant <= grant; busy <= 0; pkt_done <= 1 for one cycle; go to IDLE.

Latency and throughput:
- Source tvalid rising at edge t (while IDLE) gives m_axis_tvalid high after edge t+1.
- Zero-latency pass-through while in XFER.
- One mandatory IDLE bubble cycle between consecutive packets.

Boundary conditions:
- arb_en or tvalid of the granted source changing mid-packet does not revoke the grant. Only TLAST ends a grant.
- A single-beat packet (tlast on the first beat) takes XFER for one cycle and then IDLE.
- Simultaneous requests from all sources: strict rotation 0,1,...,NUM_SI-1,0 under continuous load.
- A lone requester is re-granted after each bubble.
- m_axis_tready low stalls the transfer with outputs held, because the source must hold data per AXIS rules. The arbiter adds no buffering.
- arb_en = 0 for all sources: stay in IDLE regardless of tvalid.
- areset mid-packet: the packet is aborted and rotation restarts at source 0. Downstream sees a truncated packet with no TLAST, which is acceptable.
- No X on outputs in IDLE: tdata/tkeep/tuser/tlast/tdest drive 0.

Decomposition:
- Package axis_arb_pkg holds the TDATA_W=24 and TUSER_W=1 defaults, the state encoding (IDLE=0, XFER=1), and a clog2 function.
- One sub-module, rr_pick: combinational round-robin picker. Inputs req[NUM_SI] and last[GRANT_W]; outputs gnt_idx[GRANT_W] and gnt_vld.

Test Plan:
1. Reset, then source 0 sends a 16-beat packet, tdata 0x000000..0x00000F, tlast on beat 16 -> m_axis carries identical data with tdest=0; pkt_done pulses once; busy is high for 16 cycles.
2. Both sources continuously valid with 4-beat packets, NUM_SI=2 -> grant order 0,1,0,1; each grant covers exactly 4 beats; one IDLE cycle between packets.
3. Source 1 mid-packet (beat 3 of 8) with m_axis_tready toggling 1010... and source 0 asserting tvalid -> no interleave; all 8 beats of source 1 complete before source 0 gets tdest=0.
4. arb_en=2'b01 with both sources valid -> only source 0 is granted. Then set arb_en=2'b11 while source 0 is mid-packet -> source 1 is granted next.
5. Assert areset on beat 5 of 16 -> m_axis_tvalid drops asynchronously; after release, the first grant goes to source 0.
6. Source 1 sends a 1-beat packet (tlast=1, tdata=0xABCDEF, tuser=1) -> one transfer with tdest=1 and tuser=1; back to IDLE on the next cycle.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared defaults, FSM encoding and elaboration helpers for the packet round-robin arbiter.
package axis_arb_pkg;

  localparam int TDATA_W_DEF = 24;
  localparam int TUSER_W_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping; zero latency.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SI  = 2,
  parameter int GRANT_W = 1
) (
  input  logic [NUM_SI-1:0]  req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] gnt_idx,
  output logic               gnt_vld
);

  // Offset k=1 is the highest priority, k=NUM_SI (last itself) the lowest.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_SI; k++) begin
      if (!gnt_vld && req[(int'(last) + k) % NUM_SI]) begin
        gnt_vld = 1'b1;
        gnt_idx = GRANT_W'((int'(last) + k) % NUM_SI);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular AXIS round-robin arbiter; one registered grant cycle, then zero-latency pass-through.
// Backpressure flows straight from m_axis_tready to the granted source; no internal buffering.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_SI  = 2,
  parameter  int TDATA_W = TDATA_W_DEF,
  parameter  int TUSER_W = TUSER_W_DEF,
  localparam int GRANT_W = (clog2(NUM_SI) > 1) ? clog2(NUM_SI) : 1,
  localparam int TKEEP_W = TDATA_W / 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_SI-1:0]         arb_en,
  input  logic [NUM_SI-1:0]         s_axis_tvalid,
  output logic [NUM_SI-1:0]         s_axis_tready,
  input  logic [NUM_SI*TDATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SI*TKEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_SI-1:0]         s_axis_tlast,
  input  logic [NUM_SI*TUSER_W-1:0] s_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [TDATA_W-1:0]        m_axis_tdata,
  output logic [TKEEP_W-1:0]        m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [TUSER_W-1:0]        m_axis_tuser,
  output logic [GRANT_W-1:0]        m_axis_tdest,
  output logic                      busy,
  output logic                      pkt_done
);

  state_t               state;
  state_t               state_nxt;
  logic [GRANT_W-1:0]   grant;
  logic [GRANT_W-1:0]   last_grant;
  logic [NUM_SI-1:0]    req;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_vld;
  logic                 xfer_end;

  assign req = s_axis_tvalid & arb_en;

  rr_pick #(
    .NUM_SI  (NUM_SI),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .req     (req),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from state so an async reset silences both sides immediately.
  always_comb begin
    state_nxt     = state;
    xfer_end      = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tdest  = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        m_axis_tvalid        = s_axis_tvalid[grant];
        m_axis_tdata         = s_axis_tdata[grant*TDATA_W +: TDATA_W];
        m_axis_tkeep         = s_axis_tkeep[grant*TKEEP_W +: TKEEP_W];
        m_axis_tlast         = s_axis_tlast[grant];
        m_axis_tuser         = s_axis_tuser[grant*TUSER_W +: TUSER_W];
        m_axis_tdest         = grant;
        s_axis_tready[grant] = m_axis_tready;
        xfer_end             = s_axis_tvalid[grant] & m_axis_tready & s_axis_tlast[grant];
        if (xfer_end) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // last_grant only moves on a completed packet, so an aborted one never advances rotation.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant      <= '0;
      last_grant <= GRANT_W'(NUM_SI - 1);
      busy       <= 1'b0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (state == IDLE && pick_vld) begin
        grant <= pick_idx;
        busy  <= 1'b1;
      end
      if (state == XFER && xfer_end) begin
        last_grant <= grant;
        busy       <= 1'b0;
        pkt_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter with two behavioural AXIS sources and a beat log.
module tb_axis_pkt_rr_arbiter;

  localparam int NUM_SI  = 2;
  localparam int TDATA_W = 24;
  localparam int TUSER_W = 1;
  localparam int GRANT_W = 1;
  localparam int TKEEP_W = 3;

  logic                      aclk = 1'b0;
  logic                      areset;
  logic [NUM_SI-1:0]         arb_en;
  logic [NUM_SI-1:0]         s_axis_tvalid;
  logic [NUM_SI-1:0]         s_axis_tready;
  logic [NUM_SI*TDATA_W-1:0] s_axis_tdata;
  logic [NUM_SI*TKEEP_W-1:0] s_axis_tkeep;
  logic [NUM_SI-1:0]         s_axis_tlast;
  logic [NUM_SI*TUSER_W-1:0] s_axis_tuser;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [TDATA_W-1:0]        m_axis_tdata;
  logic [TKEEP_W-1:0]        m_axis_tkeep;
  logic                      m_axis_tlast;
  logic [TUSER_W-1:0]        m_axis_tuser;
  logic [GRANT_W-1:0]        m_axis_tdest;
  logic                      busy;
  logic                      pkt_done;

  axis_pkt_rr_arbiter #(
    .NUM_SI  (NUM_SI),
    .TDATA_W (TDATA_W),
    .TUSER_W (TUSER_W)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .arb_en        (arb_en),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tdest  (m_axis_tdest),
    .busy          (busy),
    .pkt_done      (pkt_done)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt;
  int busy_cnt;
  bit rdy_toggle;

  int          src_len  [NUM_SI];
  int          src_beat [NUM_SI];
  int          src_pkt  [NUM_SI];
  int          src_npkt [NUM_SI];
  logic [23:0] src_base [NUM_SI];
  logic        src_user [NUM_SI];

  logic [GRANT_W-1:0] log_dest [$];
  logic [TDATA_W-1:0] log_data [$];
  logic [TKEEP_W-1:0] log_keep [$];
  logic               log_last [$];
  logic [TUSER_W-1:0] log_user [$];
  int                 log_cyc  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NUM_SI; s++) begin
      s_axis_tvalid[s] = (src_len[s] != 0);
      s_axis_tdata[s*TDATA_W +: TDATA_W] = src_base[s] + 24'(src_pkt[s] * 16 + src_beat[s]);
      s_axis_tkeep[s*TKEEP_W +: TKEEP_W] = (s == 0) ? 3'b111 : 3'b011;
      s_axis_tlast[s] = (src_len[s] != 0) && (src_beat[s] == src_len[s] - 1);
      s_axis_tuser[s] = src_user[s];
    end
  endtask

  task automatic start_src(input int s, input int len, input int npkt,
                           input logic [23:0] base, input logic user);
    src_len[s]  = len;
    src_npkt[s] = npkt;
    src_beat[s] = 0;
    src_pkt[s]  = 0;
    src_base[s] = base;
    src_user[s] = user;
    drive();
  endtask

  // Observe at the falling edge, then advance sources just after the rising edge.
  task automatic cycle();
    logic [NUM_SI-1:0] fire;
    @(negedge aclk);
    if (m_axis_tvalid && m_axis_tready) begin
      log_dest.push_back(m_axis_tdest);
      log_data.push_back(m_axis_tdata);
      log_keep.push_back(m_axis_tkeep);
      log_last.push_back(m_axis_tlast);
      log_user.push_back(m_axis_tuser);
      log_cyc.push_back(cyc);
    end
    if (pkt_done) done_cnt++;
    if (busy) busy_cnt++;
    fire = s_axis_tvalid & s_axis_tready;
    @(posedge aclk);
    #1;
    cyc++;
    for (int s = 0; s < NUM_SI; s++) begin
      if (fire[s]) begin
        if (src_beat[s] == src_len[s] - 1) begin
          src_beat[s] = 0;
          src_pkt[s]++;
          if (src_pkt[s] == src_npkt[s]) src_len[s] = 0;
        end else begin
          src_beat[s]++;
        end
      end
    end
    if (rdy_toggle) m_axis_tready = ~m_axis_tready;
    drive();
  endtask

  task automatic clear_log();
    log_dest.delete();
    log_data.delete();
    log_keep.delete();
    log_last.delete();
    log_user.delete();
    log_cyc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int s = 0; s < NUM_SI; s++) start_src(s, 0, 0, 24'h0, 1'b0);
    arb_en        = 2'b11;
    m_axis_tready = 1'b1;
    rdy_toggle    = 1'b0;
    drive();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    clear_log();
  endtask

  initial begin
    int c0;
    bit s0_started;
    areset = 1'b1;

    // Test 1: reset state, then one 16-beat packet from source 0.
    do_reset();
    areset = 1'b1;
    #1;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_s_tready", 32'(s_axis_tready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pkt_done", 32'(pkt_done), 32'h0);
    check("rst_tdest", 32'(m_axis_tdest), 32'h0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    start_src(0, 16, 1, 24'h000000, 1'b0);
    c0 = cyc;
    repeat (20) cycle();
    check("t1_beats", 32'(log_data.size()), 32'd16);
    check("t1_first_cyc", 32'(log_cyc.size() > 0 ? log_cyc[0] - c0 : -1), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i < log_data.size()) begin
        check("t1_data", 32'(log_data[i]), 32'(i));
        check("t1_dest", 32'(log_dest[i]), 32'h0);
        check("t1_last", 32'(log_last[i]), 32'(i == 15));
      end
    end
    check("t1_pkt_done", 32'(done_cnt), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd16);

    // Test 2: both sources saturated with 4-beat packets.
    do_reset();
    start_src(0, 4, 2, 24'h000100, 1'b0);
    start_src(1, 4, 2, 24'h000200, 1'b0);
    c0 = cyc;
    repeat (25) cycle();
    check("t2_beats", 32'(log_data.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < log_data.size()) begin
        check("t2_dest", 32'(log_dest[i]), 32'((i / 4) % 2));
        check("t2_data", 32'(log_data[i]),
              32'(((i / 4) % 2 == 0 ? 32'h100 : 32'h200) + (i / 8) * 16 + i % 4));
        check("t2_keep", 32'(log_keep[i]), ((i / 4) % 2 == 0) ? 32'h7 : 32'h3);
        check("t2_cycle", 32'(log_cyc[i] - c0), 32'(1 + i + i / 4));
      end
    end
    check("t2_pkt_done", 32'(done_cnt), 32'd4);

    // Test 3: source 0 requests while source 1 is mid-packet under toggling ready.
    do_reset();
    rdy_toggle = 1'b1;
    s0_started = 1'b0;
    start_src(1, 8, 1, 24'h000300, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!s0_started && src_beat[1] == 3) begin
        check("t3_hold_busy", 32'(busy), 32'h1);
        check("t3_hold_dest", 32'(m_axis_tdest), 32'h1);
        start_src(0, 2, 1, 24'h000400, 1'b0);
        s0_started = 1'b1;
      end
    end
    check("t3_beats", 32'(log_data.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < log_data.size()) begin
        check("t3_dest", 32'(log_dest[i]), (i < 8) ? 32'h1 : 32'h0);
        check("t3_data", 32'(log_data[i]), (i < 8) ? 32'(32'h300 + i) : 32'(32'h400 + i - 8));
      end
    end

    // Test 4: all sources masked, then only source 0, then source 1 re-enabled mid-packet.
    do_reset();
    arb_en = 2'b00;
    start_src(0, 4, 3, 24'h000500, 1'b0);
    start_src(1, 4, 1, 24'h000600, 1'b0);
    repeat (5) cycle();
    check("t4_masked_beats", 32'(log_data.size()), 32'd0);
    check("t4_masked_busy", 32'(busy_cnt), 32'd0);
    check("t4_idle_tdata", 32'(m_axis_tdata), 32'h0);
    check("t4_idle_tlast", 32'(m_axis_tlast), 32'h0);
    arb_en = 2'b01;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (src_pkt[0] == 1 && src_beat[0] == 1) arb_en = 2'b11;
    end
    check("t4_beats", 32'(log_data.size()), 32'd16);
    for (int p = 0; p < 4; p++) begin
      if (p * 4 < log_data.size()) begin
        check("t4_pkt_dest", 32'(log_dest[p*4]), (p == 2) ? 32'h1 : 32'h0);
        check("t4_pkt_data", 32'(log_data[p*4]),
              (p == 2) ? 32'h600 : ((p == 3) ? 32'h520 : 32'(32'h500 + p * 16)));
      end
    end

    // Test 5: reset during beat 5 of 16 aborts the packet and restarts rotation.
    do_reset();
    start_src(0, 16, 1, 24'h000700, 1'b0);
    for (int i = 0; i < 20 && src_beat[0] != 4; i++) cycle();
    check("t5_pre_beats", 32'(log_data.size()), 32'd4);
    areset = 1'b1;
    #1;
    check("t5_async_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("t5_async_tready", 32'(s_axis_tready), 32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    clear_log();
    start_src(0, 2, 1, 24'h000710, 1'b0);
    start_src(1, 1, 1, 24'h000800, 1'b0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (12) cycle();
    check("t5_beats", 32'(log_data.size()), 32'd3);
    if (log_data.size() >= 3) begin
      check("t5_first_dest", 32'(log_dest[0]), 32'h0);
      check("t5_first_data", 32'(log_data[0]), 32'h710);
      check("t5_third_dest", 32'(log_dest[2]), 32'h1);
      check("t5_third_data", 32'(log_data[2]), 32'h800);
    end
    check("t5_pkt_done", 32'(done_cnt), 32'd2);

    // Test 6: single-beat packet from source 1 with tuser set.
    do_reset();
    start_src(1, 1, 1, 24'hABCDEF, 1'b1);
    repeat (6) cycle();
    check("t6_beats", 32'(log_data.size()), 32'd1);
    if (log_data.size() >= 1) begin
      check("t6_dest", 32'(log_dest[0]), 32'h1);
      check("t6_data", 32'(log_data[0]), 32'hABCDEF);
      check("t6_user", 32'(log_user[0]), 32'h1);
      check("t6_last", 32'(log_last[0]), 32'h1);
    end
    check("t6_busy_cycles", 32'(busy_cnt), 32'd1);
    check("t6_pkt_done", 32'(done_cnt), 32'd1);
    check("t6_end_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
